vga_plot_queue: RTL and testbench

Buffered responder for the pixel plot interface (plot, x, y, colour) used by the screen-drawing blocks. It accepts pixel writes from an upstream initiator (init_screen, game_plot or any later drawing block) with waitrequest backpressure. Writes are stored in a DEPTH-entry FIFO and replayed, optionally throttled, onto the vga_adapter write port. It sits between the top-level plot mux and vga_adapter, so drawing blocks can burst without losing pixels.

---
 rtl/vga_plot_queue.sv | 117 +++++++++++
 tb/tb_vga_plot_queue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_queue.sv
// Pixel-write FIFO between the plot mux and vga_adapter: absorbs bursts with
// waitrequest backpressure and replays them at most once every DRAIN_DIV cycles.
module vga_plot_queue #(
  parameter int DEPTH     = 16,
  parameter int DRAIN_DIV = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_plot,
  input  logic [7:0]               in_x,
  input  logic [6:0]               in_y,
  input  logic [2:0]               in_colour,
  output logic                     waitrequest,
  input  logic                     flush,
  output logic                     out_plot,
  output logic [7:0]               out_x,
  output logic [6:0]               out_y,
  output logic [2:0]               out_colour,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [DW-1:0] DIV_LOAD = DW'(DRAIN_DIV - 1);

  logic [17:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] div_q, div_d;
  logic          out_plot_q, out_plot_d;
  logic [7:0]    out_x_q, out_x_d;
  logic [6:0]    out_y_q, out_y_d;
  logic [2:0]    out_colour_q, out_colour_d;
  logic          dropped_q, dropped_d;
  logic          in_range;
  logic          push;
  logic          pop;

  // waitrequest depends only on registered occupancy, never on in_plot
  assign waitrequest = (count_q == FULL);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    div_d        = div_q;
    out_plot_d   = 1'b0;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_colour_d = out_colour_q;
    dropped_d    = dropped_q;
    in_range     = (in_x < 8'd160) && (in_y < 7'd120);
    push         = in_plot && !waitrequest && in_range && !flush;
    pop          = (count_q != '0) && (div_q == '0) && !flush;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      div_d     = '0;
      dropped_d = 1'b0;
    end else begin
      if (in_plot && waitrequest) dropped_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        {out_x_d, out_y_d, out_colour_d} = mem_q[rd_ptr_q];
        out_plot_d = 1'b1;
        div_d      = DIV_LOAD;
      end else if (div_q != '0) begin
        div_d = div_q - DW'(1);
      end
      // Out-of-range writes are accepted but never occupy a slot
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_x, in_y, in_colour};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      div_q        <= '0;
      out_plot_q   <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_colour_q <= '0;
      dropped_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      div_q        <= div_d;
      out_plot_q   <= out_plot_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_colour_q <= out_colour_d;
      dropped_q    <= dropped_d;
    end
  end

  assign out_plot   = out_plot_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_colour = out_colour_q;
  assign count      = count_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_vga_plot_queue.sv
// Bench for vga_plot_queue: three configurations share stimulus, one selected
// at a time; a cycle model plus a pixel scoreboard predicts every output.
module tb_vga_plot_queue;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, t_plot, t_flush;
  logic [7:0] t_x;
  logic [6:0] t_y;
  logic [2:0] t_c;
  int         sel;

  logic pl_a, pl_b, pl_c;
  assign pl_a = t_plot && (sel == 0);
  assign pl_b = t_plot && (sel == 1);
  assign pl_c = t_plot && (sel == 2);

  logic       wr_a, op_a, dr_a, wr_b, op_b, dr_b, wr_c, op_c, dr_c;
  logic [7:0] ox_a, ox_b, ox_c;
  logic [6:0] oy_a, oy_b, oy_c;
  logic [2:0] oc_a, oc_b, oc_c;
  logic [4:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;

  vga_plot_queue #(.DEPTH(16), .DRAIN_DIV(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_plot(pl_a), .in_x(t_x), .in_y(t_y), .in_colour(t_c),
    .waitrequest(wr_a), .flush(t_flush), .out_plot(op_a), .out_x(ox_a), .out_y(oy_a),
    .out_colour(oc_a), .count(cnt_a), .dropped(dr_a));
  vga_plot_queue #(.DEPTH(16), .DRAIN_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_plot(pl_b), .in_x(t_x), .in_y(t_y), .in_colour(t_c),
    .waitrequest(wr_b), .flush(t_flush), .out_plot(op_b), .out_x(ox_b), .out_y(oy_b),
    .out_colour(oc_b), .count(cnt_b), .dropped(dr_b));
  vga_plot_queue #(.DEPTH(4), .DRAIN_DIV(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_plot(pl_c), .in_x(t_x), .in_y(t_y), .in_colour(t_c),
    .waitrequest(wr_c), .flush(t_flush), .out_plot(op_c), .out_x(ox_c), .out_y(oy_c),
    .out_colour(oc_c), .count(cnt_c), .dropped(dr_c));

  logic       o_wr, o_plot, o_drop;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_c;
  logic [4:0] o_cnt;

  always_comb begin
    o_wr = wr_c; o_plot = op_c; o_drop = dr_c; o_x = ox_c; o_y = oy_c; o_c = oc_c;
    o_cnt = {2'b00, cnt_c};
    if (sel == 0) begin
      o_wr = wr_a; o_plot = op_a; o_drop = dr_a; o_x = ox_a; o_y = oy_a; o_c = oc_a; o_cnt = cnt_a;
    end else if (sel == 1) begin
      o_wr = wr_b; o_plot = op_b; o_drop = dr_b; o_x = ox_b; o_y = oy_b; o_c = oc_b; o_cnt = cnt_b;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;
  int m_cnt, m_div, cur_depth, cur_div;
  logic m_drop, m_plot;
  logic [17:0] sb[$];
  logic [17:0] exp_pix;

  // Applies one cycle of stimulus, advances the reference model, then waits past the edge
  task automatic cyc(input logic p, input logic [7:0] x, input logic [6:0] y,
                     input logic [2:0] c, input logic f);
    logic full, push, pop;
    t_plot = p; t_x = x; t_y = y; t_c = c; t_flush = f;
    full = (m_cnt == cur_depth);
    if (!rst_n || f) begin
      m_cnt = 0; m_div = 0; m_drop = 1'b0; m_plot = 1'b0;
      sb.delete();
    end else begin
      push = p && !full && (x < 8'd160) && (y < 7'd120);
      pop  = (m_cnt != 0) && (m_div == 0);
      if (p && full) m_drop = 1'b1;
      m_plot = pop;
      if (push) sb.push_back({x, y, c});
      m_div = pop ? cur_div - 1 : ((m_div > 0) ? m_div - 1 : 0);
      m_cnt = m_cnt + int'(push) - int'(pop);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    cur_depth = (s == 2) ? 4 : 16;
    cur_div   = (s == 0) ? 4 : 1;
    rst_n = 1'b0;
    cyc(0, 8'd0, 7'd0, 3'd0, 0);
    cyc(0, 8'd0, 7'd0, 3'd0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(0);
    n_chk++;
    if ({o_plot, o_cnt, o_drop, o_wr} !== 8'd0) $display("FAIL reset_ctrl got plot=%b cnt=%0d drop=%b wr=%b want all 0", o_plot, o_cnt, o_drop, o_wr);
    else n_pass++;
    n_chk++;
    if ({o_x, o_y, o_c} !== 18'd0) $display("FAIL reset_pixel got %h want 0", {o_x, o_y, o_c});
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset(0);
    cyc(1, 8'd5, 7'd7, 3'b101, 0);
    n_chk++;
    if (o_cnt !== 5'd1 || o_plot !== 1'b0) $display("FAIL single_accept got cnt=%0d plot=%b want 1/0", o_cnt, o_plot);
    else n_pass++;
    cyc(0, 8'd0, 7'd0, 3'd0, 0);
    n_chk++;
    if ({o_plot, o_x, o_y, o_c} !== {1'b1, 8'd5, 7'd7, 3'd5} || o_cnt !== 5'd0)
      $display("FAIL single_emit got plot=%b x=%0d y=%0d c=%0d cnt=%0d want 1 5 7 5 0", o_plot, o_x, o_y, o_c, o_cnt);
    else n_pass++;
    cyc(0, 8'd0, 7'd0, 3'd0, 0);
    n_chk++;
    if (o_plot !== 1'b0 || o_drop !== 1'b0) $display("FAIL single_after got plot=%b drop=%b want 0/0", o_plot, o_drop);
    else n_pass++;
  endtask

  task automatic test_fill();
    int last = -1;
    int emitted = 0;
    logic saw_wr = 1'b0;
    do_reset(0);
    for (int t = 0; t < 24 + 72; t++) begin
      if (t < 24) cyc(1, 8'(t), 7'd0, 3'(t % 8), 0);
      else        cyc(0, 8'd0, 7'd0, 3'd0, 0);
      if (o_wr) saw_wr = 1'b1;
      n_chk++;
      if (o_cnt !== 5'(m_cnt) || o_wr !== (m_cnt == 16) || o_drop !== m_drop || o_plot !== m_plot)
        $display("FAIL fill_state t=%0d got cnt=%0d wr=%b drop=%b plot=%b want %0d %b %b %b",
                 t, o_cnt, o_wr, o_drop, o_plot, m_cnt, (m_cnt == 16), m_drop, m_plot);
      else n_pass++;
      if (o_plot) begin
        emitted++;
        n_chk++;
        exp_pix = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
        if ({o_x, o_y, o_c} !== exp_pix) $display("FAIL fill_order got %h want %h", {o_x, o_y, o_c}, exp_pix);
        else n_pass++;
        if (last >= 0) begin
          n_chk++;
          if (t - last != 4) $display("FAIL fill_gap got %0d want 4", t - last);
          else n_pass++;
        end
        last = t;
      end
    end
    n_chk++;
    if (!saw_wr || o_drop !== 1'b1 || emitted != 22)
      $display("FAIL fill_summary got wr_seen=%b drop=%b emitted=%0d want 1 1 22", saw_wr, o_drop, emitted);
    else n_pass++;
  endtask

  task automatic test_stream();
    int highs = 0;
    int run = 0;
    int best = 0;
    do_reset(1);
    for (int t = 0; t < 102; t++) begin
      cyc(t < 100, 8'(t), 7'(t % 120), 3'(t % 8), 0);
      n_chk++;
      if (o_wr !== 1'b0 || o_cnt > 5'd1 || o_plot !== m_plot)
        $display("FAIL stream_state t=%0d got wr=%b cnt=%0d plot=%b want 0 <=1 %b", t, o_wr, o_cnt, o_plot, m_plot);
      else n_pass++;
      if (o_plot) begin
        highs++; run++;
        if (run > best) best = run;
        n_chk++;
        exp_pix = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
        if ({o_x, o_y, o_c} !== exp_pix) $display("FAIL stream_order got %h want %h", {o_x, o_y, o_c}, exp_pix);
        else n_pass++;
      end else run = 0;
    end
    n_chk++;
    if (highs != 100 || best != 100) $display("FAIL stream_run got highs=%0d run=%0d want 100 100", highs, best);
    else n_pass++;
  endtask

  task automatic test_bounds();
    int emitted = 0;
    do_reset(0);
    for (int t = 0; t < 11; t++) begin
      case (t)
        0:       cyc(1, 8'd160, 7'd0,   3'd1, 0);
        1:       cyc(1, 8'd0,   7'd120, 3'd2, 0);
        2:       cyc(1, 8'd159, 7'd119, 3'd6, 0);
        default: cyc(0, 8'd0,   7'd0,   3'd0, 0);
      endcase
      n_chk++;
      if (o_cnt > 5'd1 || o_plot !== m_plot) $display("FAIL bounds_state t=%0d got cnt=%0d plot=%b want <=1 %b", t, o_cnt, o_plot, m_plot);
      else n_pass++;
      if (o_plot) begin
        emitted++;
        n_chk++;
        if ({o_x, o_y, o_c} !== {8'd159, 7'd119, 3'd6}) $display("FAIL bounds_pixel got %h want %h", {o_x, o_y, o_c}, {8'd159, 7'd119, 3'd6});
        else n_pass++;
      end
    end
    n_chk++;
    if (emitted != 1 || o_drop !== 1'b0) $display("FAIL bounds_summary got emitted=%0d drop=%b want 1 0", emitted, o_drop);
    else n_pass++;
  endtask

  task automatic test_flush();
    int late = 0;
    do_reset(0);
    for (int t = 0; t < 10; t++) begin
      cyc(1, 8'(t + 40), 7'(t), 3'(t % 8), 0);
      if (o_plot) begin
        n_chk++;
        exp_pix = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
        if ({o_x, o_y, o_c} !== exp_pix) $display("FAIL flush_pre_order got %h want %h", {o_x, o_y, o_c}, exp_pix);
        else n_pass++;
      end
    end
    cyc(1, 8'd9, 7'd9, 3'd1, 1);
    n_chk++;
    if (o_cnt !== 5'd0 || o_plot !== 1'b0 || o_drop !== 1'b0 || o_wr !== 1'b0)
      $display("FAIL flush_clear got cnt=%0d plot=%b drop=%b wr=%b want 0 0 0 0", o_cnt, o_plot, o_drop, o_wr);
    else n_pass++;
    for (int t = 0; t < 12; t++) begin
      cyc(0, 8'd0, 7'd0, 3'd0, 0);
      if (o_plot) late++;
    end
    n_chk++;
    if (late != 0 || o_cnt !== 5'd0) $display("FAIL flush_quiet got plots=%0d cnt=%0d want 0 0", late, o_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int emitted = 0;
    do_reset(2);
    for (int t = 0; t < 24; t++) begin
      if (t < 20 && (t % 4) < 2) cyc(1, 8'(100 + (t / 4) * 2 + (t % 4)), 7'(t), 3'(t % 8), 0);
      else                       cyc(0, 8'd0, 7'd0, 3'd0, 0);
      n_chk++;
      if (o_plot !== m_plot || o_cnt !== 5'(m_cnt)) $display("FAIL wrap_state t=%0d got plot=%b cnt=%0d want %b %0d", t, o_plot, o_cnt, m_plot, m_cnt);
      else n_pass++;
      if (o_plot) begin
        emitted++;
        n_chk++;
        exp_pix = (sb.size() > 0) ? sb.pop_front() : 18'h3ffff;
        if ({o_x, o_y, o_c} !== exp_pix) $display("FAIL wrap_order got %h want %h", {o_x, o_y, o_c}, exp_pix);
        else n_pass++;
      end
    end
    n_chk++;
    if (emitted != 10 || sb.size() != 0) $display("FAIL wrap_summary got emitted=%0d left=%0d want 10 0", emitted, sb.size());
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; t_plot = 1'b0; t_flush = 1'b0; t_x = '0; t_y = '0; t_c = '0; sel = 0;
    m_cnt = 0; m_div = 0; m_drop = 1'b0; m_plot = 1'b0; cur_depth = 16; cur_div = 4;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_reset();
    test_fill();
    test_stream();
    test_bounds();
    test_flush();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
